// File: rtl/player_motion_ctrl.sv
// Tick-paced player motion FSM (walk, ladder climb, jump arc) with a clamped, registered sprite position.
// Latency: each decision is visible one cycle after the tick strobe. There is no backpressure; inputs are sampled only on tick.
module player_motion_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int STEP     = 2,
    parameter int JUMP_H   = 8,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 624,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 464,
    parameter int X_INIT   = 16,
    parameter int Y_INIT   = 448
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] move_state,
    input  logic       on_ground,
    input  logic       on_ladder,
    output logic [9:0] x_pos,
    output logic [8:0] y_pos,
    output logic       jumping,
    output logic       facing,
    output logic       tick
);

    localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int JCNT_W = $clog2(JUMP_H + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [JCNT_W-1:0] JCNT_LAST = JCNT_W'(JUMP_H - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WALK  = 3'd1;
    localparam logic [2:0] S_CLIMB = 3'd2;
    localparam logic [2:0] S_RISE  = 3'd3;
    localparam logic [2:0] S_FALL  = 3'd4;

    localparam logic [1:0] HDIR_NONE  = 2'd0;
    localparam logic [1:0] HDIR_LEFT  = 2'd1;
    localparam logic [1:0] HDIR_RIGHT = 2'd2;

    localparam logic [2:0] CMD_UP    = 3'b001;
    localparam logic [2:0] CMD_LEFT  = 3'b010;
    localparam logic [2:0] CMD_RIGHT = 3'b011;
    localparam logic [2:0] CMD_DOWN  = 3'b100;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic              facing_q, facing_d;
    logic [JCNT_W-1:0] jcnt_q, jcnt_d;
    logic [1:0]        hdir_q, hdir_d;

    // Saturating steps: one spare bit catches carry/borrow before the clamp.
    function automatic logic [9:0] x_inc(input logic [9:0] x);
        logic [10:0] s;
        s = {1'b0, x} + 11'(STEP);
        if (s > 11'(X_MAX)) return 10'(X_MAX);
        return s[9:0];
    endfunction

    function automatic logic [9:0] x_dec(input logic [9:0] x);
        logic [10:0] s;
        s = {1'b0, x} - 11'(STEP);
        if (s[10] || (s < 11'(X_MIN))) return 10'(X_MIN);
        return s[9:0];
    endfunction

    function automatic logic [8:0] y_inc(input logic [8:0] y);
        logic [9:0] s;
        s = {1'b0, y} + 10'(STEP);
        if (s > 10'(Y_MAX)) return 9'(Y_MAX);
        return s[8:0];
    endfunction

    function automatic logic [8:0] y_dec(input logic [8:0] y);
        logic [9:0] s;
        s = {1'b0, y} - 10'(STEP);
        if (s[9] || (s < 10'(Y_MIN))) return 9'(Y_MIN);
        return s[8:0];
    endfunction

    logic       jump_cmd;
    logic [2:0] dir_cmd;
    logic       cmd_up, cmd_down, cmd_left, cmd_right;
    logic [9:0] x_air;

    assign jump_cmd  = move_state[3];
    assign dir_cmd   = move_state[2:0];
    assign cmd_up    = (dir_cmd == CMD_UP);
    assign cmd_down  = (dir_cmd == CMD_DOWN);
    assign cmd_left  = (dir_cmd == CMD_LEFT);
    assign cmd_right = (dir_cmd == CMD_RIGHT);

    // Horizontal drift while airborne follows the direction latched at take-off.
    always_comb begin
        x_air = x_q;
        if (hdir_q == HDIR_LEFT) begin
            x_air = x_dec(x_q);
        end else if (hdir_q == HDIR_RIGHT) begin
            x_air = x_inc(x_q);
        end
    end

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        facing_d = facing_q;
        jcnt_d   = jcnt_q;
        hdir_d   = hdir_q;
        if (tick) begin
            case (state_q)
                S_IDLE, S_WALK: begin
                    if (jump_cmd && on_ground) begin
                        state_d = S_RISE;
                        jcnt_d  = '0;
                        if (cmd_left) begin
                            hdir_d = HDIR_LEFT;
                        end else if (cmd_right) begin
                            hdir_d = HDIR_RIGHT;
                        end else begin
                            hdir_d = HDIR_NONE;
                        end
                    end else if (!on_ground && !on_ladder) begin
                        state_d = S_FALL;
                        hdir_d  = HDIR_NONE;
                    end else if ((cmd_up || cmd_down) && on_ladder) begin
                        state_d = S_CLIMB;
                        y_d     = cmd_up ? y_dec(y_q) : y_inc(y_q);
                    end else if (cmd_left || cmd_right) begin
                        state_d  = S_WALK;
                        x_d      = cmd_left ? x_dec(x_q) : x_inc(x_q);
                        facing_d = cmd_right;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CLIMB: begin
                    if (on_ladder && cmd_up) begin
                        y_d = y_dec(y_q);
                    end else if (on_ladder && cmd_down) begin
                        y_d = y_inc(y_q);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RISE: begin
                    y_d    = y_dec(y_q);
                    x_d    = x_air;
                    jcnt_d = jcnt_q + 1'b1;
                    if (jcnt_q == JCNT_LAST) begin
                        state_d = S_FALL;
                    end
                end
                S_FALL: begin
                    if (on_ground) begin
                        state_d = S_IDLE;
                    end else begin
                        y_d = y_inc(y_q);
                        x_d = x_air;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            x_q      <= 10'(X_INIT);
            y_q      <= 9'(Y_INIT);
            facing_q <= 1'b1;
            jcnt_q   <= '0;
            hdir_q   <= HDIR_NONE;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            facing_q <= facing_d;
            jcnt_q   <= jcnt_d;
            hdir_q   <= hdir_d;
        end
    end

    assign tick    = (cnt_q == CNT_LAST);
    assign x_pos   = x_q;
    assign y_pos   = y_q;
    assign facing  = facing_q;
    assign jumping = (state_q == S_RISE) || (state_q == S_FALL);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: reset, tick phase, walk clamp, jump arc, ladder, ledge fall, mid-jump reset.
module tb_player_motion_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] move_state;
    logic       on_ground;
    logic       on_ladder;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic       jumping;
    logic       facing;
    logic       tick;

    int n_chk;
    int n_err;

    player_motion_ctrl #(
        .TICK_DIV (4),
        .STEP     (2),
        .JUMP_H   (3),
        .X_MIN    (10),
        .X_MAX    (624),
        .Y_MIN    (0),
        .Y_MAX    (464),
        .X_INIT   (16),
        .Y_INIT   (448)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .move_state (move_state),
        .on_ground  (on_ground),
        .on_ladder  (on_ladder),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .jumping    (jumping),
        .facing     (facing),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Let the next tick edge sample the current inputs, then park on the following falling edge.
    task automatic do_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            n_chk++;
            n_err++;
            $display("FAIL tick_timeout: got no tick within %0d cycles", n);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] tick_exp;
        logic [3:0] tick_exp2;
        int         x_walk[10];
        int         yexp;

        n_chk      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        move_state = 4'b0000;
        on_ground  = 1'b1;
        on_ladder  = 1'b0;

        // Reset values and tick phase.
        repeat (2) @(negedge clk);
        chk("rst_x", x_pos, 16);
        chk("rst_y", y_pos, 448);
        chk("rst_jumping", jumping, 0);
        chk("rst_facing", facing, 1);
        chk("rst_tick", tick, 0);
        rst_n    = 1'b1;
        tick_exp = 8'b0100_0100;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("tick_phase", tick, tick_exp[k]);
        end

        // Walk left into the X_MIN=10 clamp.
        x_walk     = '{14, 12, 10, 10, 10, 10, 10, 10, 10, 10};
        move_state = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            chk("walk_x", x_pos, x_walk[i]);
            chk("walk_facing", facing, 0);
        end
        chk("walk_y", y_pos, 448);

        // Jump right from the reset position.
        do_reset();
        move_state = 4'b1011;
        do_tick();
        chk("jump_entry_jumping", jumping, 1);
        chk("jump_entry_y", y_pos, 448);
        chk("jump_entry_x", x_pos, 16);
        move_state = 4'b0000;
        on_ground  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            do_tick();
            chk("rise_y", y_pos, 448 - 2 * i);
            chk("rise_x", x_pos, 16 + 2 * i);
            chk("rise_jumping", jumping, 1);
        end
        do_tick();
        chk("fall_y", y_pos, 444);
        chk("fall_x", x_pos, 24);
        chk("fall_jumping", jumping, 1);
        on_ground = 1'b1;
        do_tick();
        chk("land_y", y_pos, 444);
        chk("land_x", x_pos, 24);
        chk("land_jumping", jumping, 0);

        // Ladder climb; first step taken on entry, none on exit.
        on_ladder  = 1'b1;
        move_state = 4'b0001;
        for (int i = 1; i <= 3; i++) begin
            do_tick();
            chk("climb_y", y_pos, 444 - 2 * i);
            chk("climb_jumping", jumping, 0);
        end
        on_ladder = 1'b0;
        do_tick();
        chk("climb_exit_y", y_pos, 438);
        do_tick();
        chk("idle_after_climb_y", y_pos, 438);
        chk("idle_after_climb_x", x_pos, 24);

        // Walk off a ledge, fall into the Y_MAX clamp, then land.
        do_reset();
        move_state = 4'b0011;
        do_tick();
        chk("ledge_walk_x", x_pos, 18);
        chk("ledge_walk_facing", facing, 1);
        on_ground = 1'b0;
        do_tick();
        chk("ledge_fall_entry_y", y_pos, 448);
        chk("ledge_fall_entry_jumping", jumping, 1);
        for (int i = 1; i <= 10; i++) begin
            do_tick();
            yexp = (448 + 2 * i > 464) ? 464 : 448 + 2 * i;
            chk("ledge_fall_y", y_pos, yexp);
            chk("ledge_fall_x", x_pos, 18);
            chk("ledge_fall_jumping", jumping, 1);
        end
        on_ground = 1'b1;
        do_tick();
        chk("ledge_land_y", y_pos, 464);
        chk("ledge_land_jumping", jumping, 0);

        // Jump beats climb on a ladder, then reset in the middle of the rise.
        do_reset();
        on_ladder  = 1'b1;
        move_state = 4'b1001;
        do_tick();
        chk("ladder_jump_jumping", jumping, 1);
        chk("ladder_jump_y", y_pos, 448);
        move_state = 4'b0000;
        on_ladder  = 1'b0;
        do_tick();
        chk("midjump_y", y_pos, 446);
        chk("midjump_x", x_pos, 16);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_x", x_pos, 16);
        chk("midrst_y", y_pos, 448);
        chk("midrst_jumping", jumping, 0);
        chk("midrst_tick", tick, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        tick_exp2 = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_tick_phase", tick, tick_exp2[k]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
